cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 39 +++
 rtl/cdb_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Result bus between the functional units and the CDB arbiter.
//   fu_valid/fu_ready    : per-FU push handshake (packed, bit i = FU i)
//   fu_pd_s/fu_pd_v      : per-FU destination register and result value
//   fu_rob_idx           : per-FU ROB entry of the result
//   cdb_valid/cdb_*      : registered broadcast and its payload
//   regf_we/pd_s/pd_v    : register-file write port (pd_s/pd_v alias cdb_pd_s/cdb_pd_v)
// master: the FU side (drives results, observes the broadcast)
// slave : the arbiter
interface cdb_arbiter_if #(
    parameter int NUM_FU = 5,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5
);
    logic [NUM_FU-1:0] fu_valid;
    logic [NUM_FU-1:0] fu_ready;
    logic [PREG_W-1:0] fu_pd_s    [NUM_FU];
    logic [31:0]       fu_pd_v    [NUM_FU];
    logic [ROB_W-1:0]  fu_rob_idx [NUM_FU];

    logic              cdb_valid;
    logic [PREG_W-1:0] cdb_pd_s;
    logic [31:0]       cdb_pd_v;
    logic [ROB_W-1:0]  cdb_rob_idx;
    logic              regf_we;
    logic [PREG_W-1:0] pd_s;
    logic [31:0]       pd_v;

    modport master (
        output fu_valid, fu_pd_s, fu_pd_v, fu_rob_idx,
        input  fu_ready, cdb_valid, cdb_pd_s, cdb_pd_v, cdb_rob_idx,
        input  regf_we, pd_s, pd_v
    );

    modport slave (
        input  fu_valid, fu_pd_s, fu_pd_v, fu_rob_idx,
        output fu_ready, cdb_valid, cdb_pd_s, cdb_pd_v, cdb_rob_idx,
        output regf_we, pd_s, pd_v
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one QDEPTH-entry result FIFO per functional unit,
// round-robin selection of one non-empty FIFO per cycle, registered broadcast.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (queues empty, outputs zeroed)
//   flush : synchronous flush (queues empty, no broadcast next cycle)
//   bus   : cdb_arbiter_if.slave -- FU push ports and the CDB/regfile outputs
module cdb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5,
    parameter int QDEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PREG_W-1:0] q_pd_s [NUM_FU][QDEPTH];
    logic [31:0]       q_pd_v [NUM_FU][QDEPTH];
    logic [ROB_W-1:0]  q_rob  [NUM_FU][QDEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_FU];
    logic [PTR_W-1:0]  rd_ptr [NUM_FU];
    logic [CNT_W-1:0]  count  [NUM_FU];
    logic [RR_W-1:0]   rr_ptr;

    logic [NUM_FU-1:0] full, non_empty, push, pop;
    logic              grant_vld;
    logic [RR_W-1:0]   grant;
    logic [PREG_W-1:0] head_s;
    logic [31:0]       head_v;
    logic [ROB_W-1:0]  head_r;

    logic              cdb_valid_q, regf_we_q;
    logic [PREG_W-1:0] cdb_pd_s_q;
    logic [31:0]       cdb_pd_v_q;
    logic [ROB_W-1:0]  cdb_rob_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready comes from the registered count only; rst forces it high.
    // push/pop are gated by rst/flush here so the queue update needs no extra branch.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            full[i]      = (count[i] == CNT_W'(QDEPTH));
            non_empty[i] = (count[i] != '0);
            push[i]      = bus.fu_valid[i] && !full[i] && !rst && !flush;
            pop[i]       = grant_vld && (grant == RR_W'(i)) && !rst && !flush;
        end
    end

    assign bus.fu_ready = rst ? '1 : ~full;

    // Round-robin: first non-empty queue at or after rr_ptr, wrapping.
    always_comb begin : arbitrate
        int unsigned     idx;
        logic [RR_W-1:0] idx_b;
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        idx_b     = '0;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            idx_b = RR_W'(idx);
            if (!grant_vld && non_empty[idx_b]) begin
                grant_vld = 1'b1;
                grant     = idx_b;
            end
        end
    end

    assign head_s = q_pd_s[grant][rd_ptr[grant]];
    assign head_v = q_pd_v[grant][rd_ptr[grant]];
    assign head_r = q_rob[grant][rd_ptr[grant]];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                q_pd_s[i][wr_ptr[i]] <= bus.fu_pd_s[i];
                q_pd_v[i][wr_ptr[i]] <= bus.fu_pd_v[i];
                q_rob[i][wr_ptr[i]]  <= bus.fu_rob_idx[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            regf_we_q   <= 1'b0;
            // flush keeps the last payload; only reset clears it
            if (rst) begin
                cdb_pd_s_q <= '0;
                cdb_pd_v_q <= '0;
                cdb_rob_q  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
            cdb_valid_q <= grant_vld;
            regf_we_q   <= grant_vld && (head_s != '0);
            if (grant_vld) begin
                cdb_pd_s_q <= head_s;
                cdb_pd_v_q <= head_v;
                cdb_rob_q  <= head_r;
                rr_ptr     <= (grant == RR_W'(NUM_FU - 1)) ? '0 : grant + RR_W'(1);
            end
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.regf_we     = regf_we_q;
    assign bus.cdb_pd_s    = cdb_pd_s_q;
    assign bus.cdb_pd_v    = cdb_pd_v_q;
    assign bus.cdb_rob_idx = cdb_rob_q;
    assign bus.pd_s        = cdb_pd_s_q;
    assign bus.pd_v        = cdb_pd_v_q;
endmodule
